gmem_pattern_engine: RTL and testbench
======================================

Name: gmem_pattern_engine

Overview:
Synthesizable Avalon-MM master that fills a global-memory region with a deterministic per-lane incrementing pattern (WRITE mode) or reads it back and checks it (VERIFY mode). Bursts are parametrised, and width and lane count are generic. It sits on the host-side SDRAM bridge port, ahead of kernel launch, for board bring-up and regression, and replaces hand-written bench fill loops.

Parameters:
- DATA_W, 256, Avalon data width in bits; must be a multiple of LANE_W.
- LANE_W, 32, pattern lane width in bits; LANES = DATA_W/LANE_W.
- ADDR_W, 32, byte address width.
- BURST_W, 5, burstcount width.
- MAX_BURST, 16, maximum beats per burst; must be between 1 and 2^(BURST_W-1).
- CNT_W, 32, width of the beat counter and the error counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0=WRITE, 1=VERIFY; sampled with start.
- base_addr  in  ADDR_W  byte address; must be aligned to DATA_W/8.
- num_beats  in  CNT_W  total beats to transfer.
- seed  in  LANE_W  pattern offset.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  valid from done until the next start; 1 = zero mismatches.
- err_count  out  CNT_W  count of mismatching beats; saturates.
- first_err_addr  out  ADDR_W  byte address of the first mismatching beat.
- avm_address  out  ADDR_W; avm_read, avm_write  out  1; avm_burstcount  out  BURST_W.
- avm_writedata  out  DATA_W; avm_byteenable  out  DATA_W/8 (always all ones).
- avm_waitrequest  in  1; avm_readdata  in  DATA_W; avm_readdatavalid  in  1.

Behaviour:
- Reset: all outputs 0 except avm_byteenable; state IDLE. Reset mid-operation aborts immediately with no done pulse. Read beats arriving after reset are ignored.
- Pattern: beat k (0-based), lane j = seed + (k+1)*(j+1) mod 2^LANE_W. Lane 0 occupies the LSBs. The value is generated incrementally: per-lane register starts at seed and adds (j+1) per beat. No multipliers.
- Bursts: burst length = min(MAX_BURST, remaining beats). avm_address = base_addr + beats_done*(DATA_W/8), held for the whole burst.
- States:
  - IDLE: start with num_beats==0 -> DONE with pass=1. Otherwise latch inputs, clear err_count and pass -> WR_BURST (mode 0) or RD_CMD (mode 1).
  - WR_BURST: avm_write=1 with the current beat's data. A beat is accepted on a cycle with !avm_waitrequest; the pattern then advances. Address and burstcount stay constant within the burst. After the last beat of a burst: next burst, or DONE when remaining==0. Writes are back-to-back; avm_write is never dropped mid-burst.
  - RD_CMD: avm_read=1 with address and burstcount until !avm_waitrequest -> RD_DATA.
  - RD_DATA: avm_read=0. On each avm_readdatavalid, compare against the expected beat. A mismatch increments err_count and captures first_err_addr if it is the first. After the last beat of the burst: RD_CMD if beats remain, else DONE. Only one outstanding read burst is allowed.
  - DONE: done=1 for one cycle; pass = (err_count==0); -> IDLE. busy drops in the same cycle done rises.
- start while busy is ignored. readdatavalid outside RD_DATA is ignored and not counted.
- Counters wrap only by num_beats bound. err_count saturates at all ones.
- Latency: first avm_write or avm_read is asserted the cycle after start. Done follows the last accepted write beat or the last read beat by 1 cycle.

Decomposition:
- Package gmem_pattern_pkg holds:
  - state enum (IDLE, WR_BURST, RD_CMD, RD_DATA, DONE);
  - mode enum (MODE_WRITE, MODE_VERIFY);
  - function next_burst_len(remaining, MAX_BURST).
- Sub-module gmem_pattern_gen: per-lane accumulator with init(seed), advance, and a DATA_W output. It is shared by the write path and the expected-data path.

Test Plan:
- WRITE, base 0x0, num_beats 256, seed 0, MAX_BURST 16, waitrequest 0 -> 16 bursts of 16. The beat at 0x20 has lane0=2, lane7=16. Memory matches the bench fill loop exactly.
- WRITE then VERIFY of 0x400000, 256 beats -> done, pass=1, err_count=0. A random waitrequest stall at 30% changes only timing, not data.
- VERIFY with the model corrupting the beat at 0x400040, lane 3 -> err_count=1, first_err_addr=0x400040, pass=0.
- num_beats=37, MAX_BURST=16 -> burstcounts 16, 16, 5. Addresses 0x0, 0x200, 0x400.
- num_beats=0 -> done on the cycle after start, pass=1, no bus activity. start while busy is ignored (no second done).
- rst asserted mid WR_BURST -> next cycle avm_write=0, busy=0, no done. A fresh start then runs correctly.

Source files
------------

// File: rtl/gmem_pattern_pkg.sv
// Shared types and helpers for the global-memory pattern engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package gmem_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_CMD,
      RD_DATA,
      DONE
   } state_t;

   typedef enum logic {
      MODE_WRITE  = 1'b0,
      MODE_VERIFY = 1'b1
   } mode_t;

   // Beats in the next burst: whatever is left, capped at the burst limit.
   function automatic logic [31:0] next_burst_len(input logic [31:0] remaining,
                                                  input logic [31:0] max_burst);
      return (remaining < max_burst) ? remaining : max_burst;
   endfunction

endpackage

// File: rtl/gmem_pattern_gen.sv
// Per-lane incrementing pattern source: lane j steps by j+1 on every advance.
// Latency: init/advance take effect on the next clock; data_o is registered.
// Backpressure: none; the caller advances only when a beat is consumed.
module gmem_pattern_gen #(
   parameter int DATA_W = 256,
   parameter int LANE_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_i,
   input  logic [LANE_W-1:0] seed_i,
   input  logic              advance_i,
   output logic [DATA_W-1:0] data_o
);

   localparam int LANES = DATA_W / LANE_W;

   // Each lane holds the value of the beat currently on offer (beat 0 after init).
   logic [LANE_W-1:0] lane_q [LANES];

   // Accumulate lane steps; adders only, lane 0 lands in the LSBs.
   always_ff @(posedge clk) begin
      for (int j = 0; j < LANES; j++) begin
         if (rst) begin
            lane_q[j] <= '0;
         end else if (init_i) begin
            lane_q[j] <= seed_i + LANE_W'(j + 1);
         end else if (advance_i) begin
            lane_q[j] <= lane_q[j] + LANE_W'(j + 1);
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign data_o[g*LANE_W +: LANE_W] = lane_q[g];
   end

endmodule

// File: rtl/gmem_pattern_engine.sv
// Avalon-MM master that fills a region with a lane pattern or reads it back and checks it.
// Latency: first avm_write/avm_read the cycle after start; done one cycle after the last beat.
// Backpressure: holds command/data while avm_waitrequest; one read burst outstanding at a time.
module gmem_pattern_engine #(
   parameter int DATA_W    = 256,
   parameter int LANE_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int BURST_W   = 5,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      num_beats,
   input  logic [LANE_W-1:0]     seed,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      err_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   output logic [ADDR_W-1:0]     avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [BURST_W-1:0]    avm_burstcount,
   output logic [DATA_W-1:0]     avm_writedata,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   input  logic                  avm_waitrequest,
   input  logic [DATA_W-1:0]     avm_readdata,
   input  logic                  avm_readdatavalid
);
   import gmem_pattern_pkg::*;

   localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(DATA_W / 8);

   state_t              state_q, state_d;
   mode_t               mode_q, mode_d;
   logic [ADDR_W-1:0]   burst_addr_q, burst_addr_d;
   logic [ADDR_W-1:0]   beat_addr_q, beat_addr_d;
   logic [ADDR_W-1:0]   first_err_q, first_err_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;
   logic [BURST_W-1:0]  burst_len_q, burst_len_d;
   logic [BURST_W-1:0]  burst_left_q, burst_left_d;
   logic                pass_q, pass_d;

   logic                gen_init, gen_adv;
   logic [DATA_W-1:0]   gen_data;
   logic                beat_done;
   logic [BURST_W-1:0]  start_len, cont_len;

   // One generator serves both the write data and the expected read data.
   gmem_pattern_gen #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_gen (
      .clk       (clk),
      .rst       (rst),
      .init_i    (gen_init),
      .seed_i    (seed),
      .advance_i (gen_adv),
      .data_o    (gen_data)
   );

   assign start_len = BURST_W'(next_burst_len(32'(num_beats), 32'(MAX_BURST)));
   assign cont_len  = BURST_W'(next_burst_len(32'(remaining_q - CNT_W'(1)), 32'(MAX_BURST)));

   // A beat completes on an accepted write or on returned read data while waiting for it.
   assign beat_done = ((state_q == WR_BURST) && !avm_waitrequest) ||
                      ((state_q == RD_DATA) && avm_readdatavalid);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath updates for the sequencer.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      burst_addr_d = burst_addr_q;
      beat_addr_d  = beat_addr_q;
      first_err_d  = first_err_q;
      remaining_d  = remaining_q;
      err_count_d  = err_count_q;
      burst_len_d  = burst_len_q;
      burst_left_d = burst_left_q;
      pass_d       = pass_q;
      gen_init     = 1'b0;
      gen_adv      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               gen_init     = 1'b1;
               mode_d       = mode_t'(mode);
               burst_addr_d = base_addr;
               beat_addr_d  = base_addr;
               remaining_d  = num_beats;
               burst_len_d  = start_len;
               burst_left_d = start_len;
               err_count_d  = '0;
               first_err_d  = '0;
               pass_d       = 1'b0;
               if (num_beats == '0) begin
                  state_d = DONE;
               end else if (mode == MODE_VERIFY) begin
                  state_d = RD_CMD;
               end else begin
                  state_d = WR_BURST;
               end
            end
         end
         WR_BURST: ;
         RD_CMD: begin
            if (!avm_waitrequest) begin
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (avm_readdatavalid && (avm_readdata != gen_data)) begin
               if (err_count_q != '1) begin
                  err_count_d = err_count_q + CNT_W'(1);
               end
               if (err_count_q == '0) begin
                  first_err_d = beat_addr_q;
               end
            end
         end
         DONE: begin
            pass_d  = (err_count_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Common per-beat bookkeeping; burst boundaries pick the next command or finish.
      if (beat_done) begin
         gen_adv      = 1'b1;
         beat_addr_d  = beat_addr_q + BEAT_INC;
         remaining_d  = remaining_q - CNT_W'(1);
         burst_left_d = burst_left_q - BURST_W'(1);
         if (burst_left_q == BURST_W'(1)) begin
            if (remaining_q == CNT_W'(1)) begin
               state_d = DONE;
            end else begin
               state_d      = (mode_q == MODE_VERIFY) ? RD_CMD : WR_BURST;
               burst_addr_d = beat_addr_q + BEAT_INC;
               burst_len_d  = cont_len;
               burst_left_d = cont_len;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= MODE_WRITE;
         burst_addr_q <= '0;
         beat_addr_q  <= '0;
         first_err_q  <= '0;
         remaining_q  <= '0;
         err_count_q  <= '0;
         burst_len_q  <= '0;
         burst_left_q <= '0;
         pass_q       <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         burst_addr_q <= burst_addr_d;
         beat_addr_q  <= beat_addr_d;
         first_err_q  <= first_err_d;
         remaining_q  <= remaining_d;
         err_count_q  <= err_count_d;
         burst_len_q  <= burst_len_d;
         burst_left_q <= burst_left_d;
         pass_q       <= pass_d;
      end
   end

   assign busy           = (state_q == WR_BURST) || (state_q == RD_CMD) || (state_q == RD_DATA);
   assign done           = (state_q == DONE);
   assign pass           = done ? (err_count_q == '0) : pass_q;
   assign err_count      = err_count_q;
   assign first_err_addr = first_err_q;
   assign avm_address    = burst_addr_q;
   assign avm_burstcount = burst_len_q;
   assign avm_write      = (state_q == WR_BURST);
   assign avm_read       = (state_q == RD_CMD);
   assign avm_writedata  = gen_data;
   assign avm_byteenable = '1;

endmodule

// File: tb/tb_gmem_pattern_engine.sv
// Bench for gmem_pattern_engine: Avalon slave memory model with random stalls and a scoreboard
// of expected bursts and write beats, checked as the DUT issues them.
module tb_gmem_pattern_engine;

   localparam int DATA_W    = 256;
   localparam int LANE_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int BURST_W   = 5;
   localparam int MAX_BURST = 16;
   localparam int CNT_W     = 32;
   localparam int LANES     = DATA_W / LANE_W;
   localparam int BYTES     = DATA_W / 8;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [BURST_W-1:0] bc;
   } burst_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic                clk = 1'b0;
   logic                rst, start, mode;
   logic [ADDR_W-1:0]   base_addr;
   logic [CNT_W-1:0]    num_beats;
   logic [LANE_W-1:0]   seed;
   logic                busy, done, pass;
   logic [CNT_W-1:0]    err_count;
   logic [ADDR_W-1:0]   first_err_addr;
   logic [ADDR_W-1:0]   avm_address;
   logic                avm_read, avm_write;
   logic [BURST_W-1:0]  avm_burstcount;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_waitrequest;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_readdatavalid;

   int total = 0;
   int bad   = 0;

   // slave / scoreboard state
   logic [DATA_W-1:0]  mem [logic [ADDR_W-1:0]];
   burst_t             exp_burst_q [$];
   beat_t              exp_wr_q [$];
   logic [BURST_W-1:0] obs_bc [$];
   logic [ADDR_W-1:0]  obs_addr [$];
   int                 stall_pct    = 0;
   bit                 mon_en       = 1'b1;
   bit                 corrupt_en   = 1'b0;
   logic [ADDR_W-1:0]  corrupt_addr = '0;
   int                 spurious     = 0;
   int                 wr_beat      = 0;
   logic [ADDR_W-1:0]  wr_addr      = '0;
   logic [BURST_W-1:0] wr_bc        = '0;
   int                 rd_left      = 0;
   logic [ADDR_W-1:0]  rd_addr      = '0;

   always #5 clk = ~clk;

   gmem_pattern_engine #(
      .DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W),
      .BURST_W(BURST_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
      .num_beats(num_beats), .seed(seed), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
   );

   // Reference pattern by direct multiplication: beat k, lane j = seed + (k+1)*(j+1).
   function automatic logic [DATA_W-1:0] pat(input logic [LANE_W-1:0] sd, input int unsigned k);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int j = 0; j < LANES; j++) begin
         d[j*LANE_W +: LANE_W] = sd + LANE_W'((k + 1) * (j + 1));
      end
      return d;
   endfunction

   task automatic push_exp(input bit md, input logic [ADDR_W-1:0] base, input int unsigned n,
                           input logic [LANE_W-1:0] sd);
      int unsigned k;
      int unsigned bc;
      burst_t b;
      beat_t w;
      k = 0;
      while (k < n) begin
         bc = ((n - k) < MAX_BURST) ? (n - k) : MAX_BURST;
         b.addr = base + ADDR_W'(k * BYTES);
         b.bc   = BURST_W'(bc);
         exp_burst_q.push_back(b);
         if (!md) begin
            for (int i = 0; i < int'(bc); i++) begin
               w.addr = base + ADDR_W'((k + i) * BYTES);
               w.data = pat(sd, k + i);
               exp_wr_q.push_back(w);
            end
         end
         k += bc;
      end
   endtask

   // Avalon slave + monitor, evaluated at the falling edge between DUT updates.
   initial begin
      logic [DATA_W-1:0] d;
      burst_t eb;
      beat_t ew;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(negedge clk);
         avm_readdatavalid = 1'b0;
         if (rd_left > 0 && $urandom_range(99) >= stall_pct) begin
            d = mem.exists(rd_addr) ? mem[rd_addr] : '0;
            if (corrupt_en && rd_addr == corrupt_addr) d[3*LANE_W] = ~d[3*LANE_W];
            avm_readdata      = d;
            avm_readdatavalid = 1'b1;
            rd_addr           = rd_addr + ADDR_W'(BYTES);
            rd_left--;
         end else if (rd_left == 0 && spurious > 0) begin
            avm_readdata      = '1;
            avm_readdatavalid = 1'b1;
            spurious--;
         end
         avm_waitrequest = ($urandom_range(99) < stall_pct);
         if (mon_en) begin
            if (wr_beat != 0) begin
               total++;
               if (avm_write !== 1'b1) begin
                  bad++;
                  $display("FAIL wr_gap: avm_write=%b mid-burst at beat %0d, required 1", avm_write, wr_beat);
               end
            end
            if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
               if (wr_beat == 0) begin
                  obs_bc.push_back(avm_burstcount);
                  obs_addr.push_back(avm_address);
                  total++;
                  if (exp_burst_q.size() == 0) begin
                     bad++;
                     $display("FAIL wr_cmd: unexpected burst addr=%h bc=%0d, required none", avm_address, avm_burstcount);
                     wr_addr = avm_address;
                     wr_bc   = avm_burstcount;
                  end else begin
                     eb = exp_burst_q.pop_front();
                     if ({avm_address, avm_burstcount} !== {eb.addr, eb.bc}) begin
                        bad++;
                        $display("FAIL wr_cmd: got addr=%h bc=%0d, required addr=%h bc=%0d", avm_address, avm_burstcount, eb.addr, eb.bc);
                     end
                     wr_addr = eb.addr;
                     wr_bc   = eb.bc;
                  end
               end else begin
                  total++;
                  if ({avm_address, avm_burstcount} !== {wr_addr, wr_bc}) begin
                     bad++;
                     $display("FAIL wr_hold: got addr=%h bc=%0d, required addr=%h bc=%0d", avm_address, avm_burstcount, wr_addr, wr_bc);
                  end
               end
               mem[wr_addr + ADDR_W'(wr_beat * BYTES)] = avm_writedata;
               total++;
               if (exp_wr_q.size() == 0) begin
                  bad++;
                  $display("FAIL wr_data: unexpected beat data=%h, required none", avm_writedata);
               end else begin
                  ew = exp_wr_q.pop_front();
                  if (avm_writedata !== ew.data || avm_byteenable !== '1 ||
                      (wr_addr + ADDR_W'(wr_beat * BYTES)) !== ew.addr) begin
                     bad++;
                     $display("FAIL wr_data: at %h got %h be=%h, required %h at %h", wr_addr + ADDR_W'(wr_beat * BYTES), avm_writedata, avm_byteenable, ew.data, ew.addr);
                  end
               end
               wr_beat++;
               if (wr_beat >= int'(wr_bc)) wr_beat = 0;
            end
            if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
               obs_bc.push_back(avm_burstcount);
               obs_addr.push_back(avm_address);
               total++;
               if (exp_burst_q.size() == 0) begin
                  bad++;
                  $display("FAIL rd_cmd: unexpected burst addr=%h bc=%0d, required none", avm_address, avm_burstcount);
               end else begin
                  eb = exp_burst_q.pop_front();
                  if ({avm_address, avm_burstcount} !== {eb.addr, eb.bc} || rd_left != 0) begin
                     bad++;
                     $display("FAIL rd_cmd: got addr=%h bc=%0d pending=%0d, required addr=%h bc=%0d pending=0", avm_address, avm_burstcount, rd_left, eb.addr, eb.bc);
                  end
               end
               rd_addr = avm_address;
               rd_left = int'(avm_burstcount);
            end
         end
      end
   end

   // Launch one operation, wait (bounded) for done, check handshake timing around it.
   task automatic run_op(input bit md, input logic [ADDR_W-1:0] base, input int unsigned n,
                         input logic [LANE_W-1:0] sd, output int lat);
      logic [3:0] exp4;
      logic       pass_at_done;
      push_exp(md, base, n, sd);
      @(negedge clk);
      mode = md; base_addr = base; num_beats = n; seed = sd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      exp4 = (n == 0) ? 4'b0100 : {1'b1, 1'b0, ~md, md};
      total++;
      if ({busy, done, avm_write, avm_read} !== exp4) begin
         bad++;
         $display("FAIL first_cycle: busy/done/wr/rd=%b, required %b", {busy, done, avm_write, avm_read}, exp4);
      end
      while (done !== 1'b1 && lat < 5000) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_at_done: busy=%b, required 0", busy);
      end
      total++;
      if (exp_burst_q.size() + exp_wr_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: %0d bursts %0d beats left, required 0", exp_burst_q.size(), exp_wr_q.size());
      end
      pass_at_done = pass;
      @(negedge clk);
      total++;
      if ({done, pass} !== {1'b0, pass_at_done}) begin
         bad++;
         $display("FAIL done_pulse: done/pass=%b, required %b", {done, pass}, {1'b0, pass_at_done});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, pass, avm_read, avm_write} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: busy/done/pass/rd/wr=%b, required 00000", {busy, done, pass, avm_read, avm_write});
      end
      total++;
      if (err_count !== '0 || first_err_addr !== '0) begin
         bad++;
         $display("FAIL reset_err: err=%0d first=%h, required 0 0", err_count, first_err_addr);
      end
      total++;
      if (avm_address !== '0 || avm_burstcount !== '0 || avm_writedata !== '0) begin
         bad++;
         $display("FAIL reset_bus: addr=%h bc=%0d wd=%h, required zeros", avm_address, avm_burstcount, avm_writedata);
      end
      total++;
      if (avm_byteenable !== '1) begin
         bad++;
         $display("FAIL reset_be: be=%h, required all ones", avm_byteenable);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_fill();
      int lat;
      int miss;
      logic [DATA_W-1:0] w;
      stall_pct = 0;
      run_op(1'b0, 32'h0, 256, 32'h0, lat);
      total++;
      if (lat != 257) begin
         bad++;
         $display("FAIL fill_latency: done after %0d cycles, required 257", lat);
      end
      total++;
      if (pass !== 1'b1 || err_count !== '0) begin
         bad++;
         $display("FAIL fill_pass: pass=%b err=%0d, required 1 0", pass, err_count);
      end
      miss = 0;
      for (int k = 0; k < 256; k++) begin
         if (!mem.exists(ADDR_W'(k * BYTES))) miss++;
         else if (mem[ADDR_W'(k * BYTES)] !== pat(32'h0, k)) miss++;
      end
      total++;
      if (miss != 0) begin
         bad++;
         $display("FAIL fill_mem: %0d beats differ from fill loop, required 0", miss);
      end
      w = mem.exists(32'h20) ? mem[32'h20] : '0;
      total++;
      if (w[31:0] !== 32'd2 || w[255:224] !== 32'd16) begin
         bad++;
         $display("FAIL fill_0x20: lane0=%0d lane7=%0d, required 2 16", w[31:0], w[255:224]);
      end
   endtask

   task automatic test_write_verify();
      int lat;
      stall_pct = 30;
      run_op(1'b0, 32'h400000, 256, 32'h1234, lat);
      run_op(1'b1, 32'h400000, 256, 32'h1234, lat);
      total++;
      if (pass !== 1'b1 || err_count !== '0) begin
         bad++;
         $display("FAIL verify_clean: pass=%b err=%0d, required 1 0", pass, err_count);
      end
   endtask

   task automatic test_corrupt();
      int lat;
      stall_pct    = 30;
      corrupt_en   = 1'b1;
      corrupt_addr = 32'h400040;
      run_op(1'b1, 32'h400000, 256, 32'h1234, lat);
      corrupt_en = 1'b0;
      total++;
      if (err_count !== 32'd1 || first_err_addr !== 32'h400040 || pass !== 1'b0) begin
         bad++;
         $display("FAIL verify_corrupt: err=%0d first=%h pass=%b, required 1 00400040 0", err_count, first_err_addr, pass);
      end
      spurious = 3;
      repeat (6) @(negedge clk);
      total++;
      if (err_count !== 32'd1 || pass !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL stray_rdv: err=%0d pass=%b busy=%b, required 1 0 0", err_count, pass, busy);
      end
   endtask

   task automatic test_burst_37();
      int lat;
      logic [BURST_W-1:0] exp_bc [3];
      logic [ADDR_W-1:0]  exp_ad [3];
      exp_bc = '{5'd16, 5'd16, 5'd5};
      exp_ad = '{32'h0, 32'h200, 32'h400};
      stall_pct = 0;
      obs_bc.delete();
      obs_addr.delete();
      run_op(1'b0, 32'h0, 37, 32'd9, lat);
      total++;
      if (obs_bc.size() != 3) begin
         bad++;
         $display("FAIL burst37_count: %0d bursts, required 3", obs_bc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_bc[i] !== exp_bc[i] || obs_addr[i] !== exp_ad[i]) begin
               bad++;
               $display("FAIL burst37_%0d: bc=%0d addr=%h, required bc=%0d addr=%h", i, obs_bc[i], obs_addr[i], exp_bc[i], exp_ad[i]);
            end
         end
      end
   endtask

   task automatic test_zero_and_busy();
      int lat;
      int done_cnt;
      stall_pct = 0;
      run_op(1'b0, 32'h100, 0, 32'd1, lat);
      total++;
      if (lat != 1 || pass !== 1'b1) begin
         bad++;
         $display("FAIL zero_beats: done after %0d pass=%b, required 1 1", lat, pass);
      end
      push_exp(1'b0, 32'h2000, 40, 32'd5);
      @(negedge clk);
      mode = 1'b0; base_addr = 32'h2000; num_beats = 40; seed = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      mode = 1'b1; base_addr = 32'h9000; num_beats = 3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 300; c++) begin
         if (done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      total++;
      if (done_cnt != 1 || exp_burst_q.size() + exp_wr_q.size() != 0) begin
         bad++;
         $display("FAIL start_busy: %0d done pulses, %0d items left, required 1 0", done_cnt, exp_burst_q.size() + exp_wr_q.size());
      end
   endtask

   task automatic test_rst_mid();
      int lat;
      int done_cnt;
      stall_pct = 0;
      push_exp(1'b0, 32'h3000, 64, 32'd3);
      @(negedge clk);
      mode = 1'b0; base_addr = 32'h3000; num_beats = 64; seed = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(negedge clk);
      total++;
      if ({avm_write, busy, done} !== 3'b000) begin
         bad++;
         $display("FAIL rst_abort: wr/busy/done=%b, required 000", {avm_write, busy, done});
      end
      rst = 1'b0;
      done_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      total++;
      if (done_cnt != 0) begin
         bad++;
         $display("FAIL rst_no_done: %0d done pulses, required 0", done_cnt);
      end
      exp_burst_q.delete();
      exp_wr_q.delete();
      wr_beat = 0;
      rd_left = 0;
      mon_en  = 1'b1;
      run_op(1'b0, 32'h1000, 20, 32'd7, lat);
      run_op(1'b1, 32'h1000, 20, 32'd7, lat);
      total++;
      if (pass !== 1'b1 || err_count !== '0) begin
         bad++;
         $display("FAIL rst_rerun: pass=%b err=%0d, required 1 0", pass, err_count);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0;
      base_addr = '0; num_beats = '0; seed = '0;
      test_reset();
      test_write_fill();
      test_write_verify();
      test_corrupt();
      test_burst_37();
      test_zero_and_busy();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
